// File: rtl/wr_burst_arbiter.sv
// wr_burst_arbiter: round-robin arbiter sharing a FIFO write port; a burst is granted only if it fits the free space.
// Define WR_BURST_ARB_STRICT_RR_EN to make the first requester in RR order block until its burst fits.
module wr_burst_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 4,
    parameter int LWIDTH  = 3
) (
    input  logic                        wr_clk_i,
    input  logic                        aclr_i,
    input  logic [NUM_SRC-1:0]          src_req_i,
    input  logic [NUM_SRC*LWIDTH-1:0]   src_len_i,
    input  logic [NUM_SRC-1:0]          src_valid_i,
    input  logic [NUM_SRC*DWIDTH-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]          src_ready_o,
    output logic [NUM_SRC-1:0]          src_grant_o,
    input  logic [AWIDTH-1:0]           wr_usedw_i,
    input  logic                        wr_full_i,
    output logic                        wr_req_o,
    output logic [DWIDTH-1:0]           wr_data_o,
    output logic                        busy_o
);
    localparam int IW = $clog2(NUM_SRC);
    typedef enum logic [1:0] {IDLE, BURST, SETTLE} state_t;
    state_t              r_state, w_state_nx;
    logic [NUM_SRC-1:0]  r_grant, w_grant_nx;
    logic [IW-1:0]       r_last, w_last_nx, w_idx, w_win;
    logic [LWIDTH-1:0]   r_cnt, w_cnt_nx;
    logic                r_settle, w_settle_nx;
    logic [AWIDTH:0]     w_free;
    logic [NUM_SRC-1:0]  w_elig;
    logic                w_found, w_go, w_accept;
    logic [LWIDTH-1:0]   w_len  [NUM_SRC];
    logic [DWIDTH-1:0]   w_data [NUM_SRC];

    assign w_free = wr_full_i ? '0 : (AWIDTH+1)'(2**AWIDTH) - {1'b0, wr_usedw_i};

    genvar i;
    for (i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_len[i]  = src_len_i[i*LWIDTH +: LWIDTH];
        assign w_data[i] = src_data_i[i*DWIDTH +: DWIDTH];
        assign w_elig[i] = src_req_i[i] && ((AWIDTH+1)'(w_len[i]) + 1'b1 <= w_free);
    end

    // Scan sources starting just after the last grant; the first hit is the candidate.
    always_comb begin
        w_found = 1'b0;
        w_go    = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = IW'((32'(r_last) + 32'(k)) % NUM_SRC);
`ifdef WR_BURST_ARB_STRICT_RR_EN
            if (!w_found && src_req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
                w_go    = w_elig[w_idx];
            end
`else
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
                w_go    = 1'b1;
            end
`endif
        end
    end

    assign w_accept = (r_state == BURST) && |(src_valid_i & r_grant) && !wr_full_i;

    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = r_grant;
        w_last_nx   = r_last;
        w_cnt_nx    = r_cnt;
        w_settle_nx = r_settle;
        case (r_state)
            IDLE: if (w_go) begin
                w_state_nx = BURST;
                w_grant_nx = NUM_SRC'(1) << w_win;
                w_last_nx  = w_win;
                w_cnt_nx   = w_len[w_win];
            end
            BURST: if (w_accept) begin
                if (r_cnt == '0) begin
                    w_state_nx  = SETTLE;
                    w_grant_nx  = '0;
                    w_settle_nx = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            // Two idle cycles let the FIFO's pointer and usedw registers catch up with the last write.
            default: begin
                w_settle_nx = 1'b1;
                w_state_nx  = r_settle ? IDLE : SETTLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_last   <= IW'(NUM_SRC - 1);
            r_cnt    <= '0;
            r_settle <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_grant  <= w_grant_nx;
            r_last   <= w_last_nx;
            r_cnt    <= w_cnt_nx;
            r_settle <= w_settle_nx;
        end
    end

    assign busy_o      = r_state != IDLE;
    assign src_grant_o = r_grant;
    assign src_ready_o = (r_state == BURST && !wr_full_i) ? r_grant : '0;
    assign wr_req_o    = w_accept;
    assign wr_data_o   = (r_state == BURST) ? w_data[r_last] : '0;
endmodule

// File: tb/tb_wr_burst_arbiter.sv
// tb_wr_burst_arbiter: randomized scoreboard bench for wr_burst_arbiter with a queue-based arbitration model.
// Honours WR_BURST_ARB_STRICT_RR_EN when defined for the build.
`timescale 1ns/1ps
module tb_wr_burst_arbiter;
    localparam int N = 4, DW = 8, AW = 4, LW = 3;
    logic            wr_clk_i = 1'b0, aclr_i = 1'b1;
    logic [N-1:0]    src_req_i = '0, src_valid_i = '0, src_ready_o, src_grant_o;
    logic [N*LW-1:0] src_len_i = '0;
    logic [N*DW-1:0] src_data_i = '0;
    logic [AW-1:0]   wr_usedw_i = '0;
    logic            wr_full_i = 1'b0, wr_req_o, busy_o;
    logic [DW-1:0]   wr_data_o, mon_exp;
    int              total = 0, bad = 0;
    logic [DW-1:0]   exp_q [$];
    int              m_last = N - 1;
    logic [N-1:0]    pend = '0;
    int              lens [N];

    wr_burst_arbiter #(.NUM_SRC(N), .DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .wr_clk_i(wr_clk_i), .aclr_i(aclr_i), .src_req_i(src_req_i), .src_len_i(src_len_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .src_grant_o(src_grant_o), .wr_usedw_i(wr_usedw_i), .wr_full_i(wr_full_i),
        .wr_req_o(wr_req_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Every write the DUT issues must match the next word some granted burst was given.
    always @(negedge wr_clk_i) begin
        if (wr_req_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got=%0h want=no_write t=%0t", wr_data_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wr_data_o !== mon_exp) begin
                    bad++;
                    $display("FAIL wr_data got=%0h want=%0h t=%0t", wr_data_o, mon_exp, $time);
                end
            end
        end
    end

    function automatic int model_win(input int usedw, input bit full);
        int free = full ? 0 : (1 << AW) - usedw;
        for (int k = 1; k <= N; k++) begin
            int s = (m_last + k) % N;
`ifdef WR_BURST_ARB_STRICT_RR_EN
            if (pend[s]) return (lens[s] + 1 <= free) ? s : -1;
`else
            if (pend[s] && lens[s] + 1 <= free) return s;
`endif
        end
        return -1;
    endfunction

    // Caller is just past a rising edge; reset is asserted immediately.
    task automatic do_reset();
        aclr_i = 1'b1;
        exp_q.delete();
        @(negedge wr_clk_i);
        chk("rst_grant", src_grant_o, 0);
        chk("rst_ready", src_ready_o, 0);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", wr_data_o, 0);
        @(posedge wr_clk_i); #1;
        aclr_i = 1'b0;
        src_valid_i = '0;
        src_req_i = '0;
        wr_full_i = 1'b0;
        pend = '0;
        m_last = N - 1;
    endtask

    // One arbitration round plus the granted burst; vmode 0=valid held, 1=toggling, 2=random.
    task automatic arb(input int usedw, input bit full, input int vmode, input int full_at, input int rst_at);
        logic [DW-1:0] words [$];
        int w, beat, cyc, fcnt;
        @(posedge wr_clk_i); #1;
        wr_usedw_i = AW'(usedw);
        wr_full_i = full;
        src_req_i = pend;
        for (int s = 0; s < N; s++) src_len_i[s*LW +: LW] = LW'(lens[s]);
        w = model_win(usedw, full);
        @(negedge wr_clk_i);
        chk("pre_grant", src_grant_o, 0);
        chk("pre_busy", busy_o, 0);
        @(negedge wr_clk_i);
        chk("grant", src_grant_o, w < 0 ? 0 : (1 << w));
        if (w < 0) begin
            repeat (3) begin
                @(negedge wr_clk_i);
                chk("no_grant", src_grant_o, 0);
            end
            @(posedge wr_clk_i); #1;
            src_req_i = '0;
            wr_full_i = 1'b0;
            return;
        end
        m_last = w;
        pend[w] = 1'b0;
        for (int b = 0; b <= lens[w]; b++) begin
            words.push_back(DW'($urandom));
            exp_q.push_back(words[b]);
        end
        beat = 0; cyc = 0; fcnt = 0;
        while (beat <= lens[w] && cyc < 100) begin
            @(posedge wr_clk_i); #1;
            src_req_i = '0;
            if (beat == rst_at) begin
                do_reset();
                return;
            end
            src_data_i = (N*DW)'($urandom);
            src_data_i[w*DW +: DW] = words[beat];
            src_valid_i = '0;
            src_valid_i[w] = vmode == 0 ? 1'b1 : vmode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (full_at >= 0 && beat == full_at && fcnt < 3) begin
                wr_full_i = 1'b1;
                fcnt++;
            end else wr_full_i = 1'b0;
            @(negedge wr_clk_i);
            chk("burst_grant", src_grant_o, 1 << w);
            if (wr_full_i) begin
                chk("full_wr_req", wr_req_o, 0);
                chk("full_ready", src_ready_o, 0);
            end else chk("ready", src_ready_o, 1 << w);
            if (src_ready_o[w] && src_valid_i[w]) beat++;
            cyc++;
        end
        if (beat <= lens[w]) chk("burst_timeout", beat, lens[w] + 1);
        @(posedge wr_clk_i); #1;
        src_valid_i = '0;
        wr_full_i = 1'b0;
        @(negedge wr_clk_i);
        chk("settle1_grant", src_grant_o, 0);
        chk("settle1_busy", busy_o, 1);
        @(negedge wr_clk_i);
        chk("settle2_busy", busy_o, 1);
        @(negedge wr_clk_i);
        chk("idle_busy", busy_o, 0);
        chk("beats_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge wr_clk_i);
        chk("init_grant", src_grant_o, 0);
        chk("init_ready", src_ready_o, 0);
        chk("init_wr_req", wr_req_o, 0);
        chk("init_busy", busy_o, 0);
        chk("init_data", wr_data_o, 0);
        @(posedge wr_clk_i); #1;
        aclr_i = 1'b0;
        pend = 4'b0010; lens = '{0, 3, 0, 0};
        arb(0, 0, 0, -1, -1);
        @(posedge wr_clk_i); #1;
        do_reset();
        repeat (5) begin
            pend = 4'b1111; lens = '{0, 0, 0, 0};
            arb(0, 0, 0, -1, -1);
        end
        @(posedge wr_clk_i); #1;
        do_reset();
        pend = 4'b0011; lens = '{7, 1, 0, 0};
        arb(12, 0, 0, -1, -1);
        arb(8, 0, 0, -1, -1);
        arb(8, 0, 0, -1, -1);
        pend = 4'b0001; lens = '{3, 0, 0, 0};
        arb(0, 1, 0, -1, -1);
        arb(0, 0, 0, 2, -1);
        pend = 4'b0100; lens = '{0, 0, 3, 0};
        arb(0, 0, 1, -1, -1);
        @(posedge wr_clk_i); #1;
        do_reset();
        pend = 4'b0100; lens = '{0, 0, 3, 0};
        arb(0, 0, 0, -1, 1);
        pend = 4'b1111; lens = '{1, 2, 0, 3};
        arb(0, 0, 0, -1, -1);
        repeat (40) begin
            pend |= N'($urandom);
            for (int s = 0; s < N; s++) lens[s] = $urandom_range(0, 7);
            arb($urandom_range(0, 15), $urandom_range(0, 7) == 0, $urandom_range(0, 2),
                $urandom_range(0, 3) == 0 ? 1 : -1, -1);
        end
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
